// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the load/store unit and memory:
// request with grant, followed by a read-data valid strobe.
interface memory_access_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: drives the data bus, aligns load data and
// stalls the pipeline while an access is outstanding.
module memory_access_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [2:0]            MemSizeM_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    memory_access_unit_if.master  mem,
    output logic                  StallM_o,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_clr, cnt_inc, capture, timeout;
    logic [1:0]        a;
    logic              acc, is_load, legal;
    logic [3:0]        be;
    logic [31:0]       wdata, lane, load_fmt;
    logic              cnt_expired;

    assign a           = ALUResultM_i[1:0];
    assign acc         = MemReadM_i | MemWriteM_i;
    assign is_load     = MemReadM_i;
    assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

    // Byte enables, store-lane replication and alignment legality
    always_comb begin
        be    = 4'b0000;
        wdata = WriteDataM_i;
        legal = 1'b0;
        case (MemSizeM_i)
            3'b000, 3'b100: begin
                be    = 4'b0001 << a;
                wdata = {4{WriteDataM_i[7:0]}};
                legal = 1'b1;
            end
            3'b001, 3'b101: begin
                be    = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM_i[15:0]}};
                legal = ~a[0];
            end
            3'b010: begin
                be    = 4'b1111;
                legal = (a == 2'b00);
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down and extend per load size
    always_comb begin
        lane     = mem.rdata >> {a, 3'b000};
        load_fmt = lane;
        case (MemSizeM_i)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_fmt = {24'b0, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_fmt = {16'b0, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            ReadDataM_o <= '0;
            bus_err_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_err_o <= timeout;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
            if (capture)
                ReadDataM_o <= load_fmt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (acc && legal) begin
                    state_nxt = REQ;
                    cnt_clr   = 1'b1;
                end
            end
            REQ: begin
                if (mem.gnt) begin
                    if (!is_load) begin
                        state_nxt = DONE;
                    end else if (mem.rvalid) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RESP;
                        cnt_clr   = 1'b1;
                    end
                end else if (cnt_expired) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (mem.rvalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_expired) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields follow the MEM inputs, which the stall keeps frozen
    assign mem.req   = (state == REQ);
    assign mem.we    = MemWriteM_i & ~MemReadM_i;
    assign mem.addr  = {ALUResultM_i[31:2], 2'b00};
    assign mem.be    = be;
    assign mem.wdata = wdata;

    // Gated by reset so an asserted reset releases the pipeline at once
    assign StallM_o     = rst_n_i & ((state == REQ) || (state == RESP) ||
                                     ((state == IDLE) && acc && legal));
    assign misaligned_o = rst_n_i & (state == IDLE) & acc & ~legal;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed accesses push expected
// bus requests, load results, stall lengths and pulses; a monitor checks them.
module tb_memory_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  MemSize;
    logic [31:0] ALUResult, WriteData;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        misaligned, bus_err;

    memory_access_unit_if #(.DATA_WIDTH(32)) bus ();

    memory_access_unit #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .MemReadM_i   (MemRead),
        .MemWriteM_i  (MemWrite),
        .MemSizeM_i   (MemSize),
        .ALUResultM_i (ALUResult),
        .WriteDataM_i (WriteData),
        .mem          (bus),
        .StallM_o     (StallM),
        .ReadDataM_o  (ReadDataM),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          stall_q[$];
    int          mis_q[$];
    int          err_q[$];

    int          stall_run = 0;
    bit          rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the matching expectation whenever the DUT presents an event
    always @(negedge clk) begin
        if (rd_pend) begin
            rd_pend = 1'b0;
            check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) check("read_data", ReadDataM, rd_q.pop_front());
        end
        if (bus.rvalid) rd_pend = 1'b1;

        if (bus.req && bus.gnt) begin
            check("req_expected", 32'(req_q.size() > 0), 32'd1);
            if (req_q.size() > 0) begin
                req_t e;
                e = req_q.pop_front();
                check("req_addr", bus.addr, e.addr);
                check("req_be", 32'(bus.be), 32'(e.be));
                check("req_we", 32'(bus.we), 32'(e.we));
                if (e.we) check("req_wdata", bus.wdata, e.wdata);
            end
        end

        if (misaligned) begin
            check("mis_expected", 32'(mis_q.size() > 0), 32'd1);
            if (mis_q.size() > 0) void'(mis_q.pop_front());
            check("mis_no_stall", 32'(StallM), 32'd0);
            check("mis_no_req", 32'(bus.req), 32'd0);
        end

        if (bus_err) begin
            check("err_expected", 32'(err_q.size() > 0), 32'd1);
            if (err_q.size() > 0) void'(err_q.pop_front());
            check("err_req_dropped", 32'(bus.req), 32'd0);
        end

        if (StallM) begin
            stall_run++;
        end else if (stall_run > 0) begin
            check("stall_expected", 32'(stall_q.size() > 0), 32'd1);
            if (stall_q.size() > 0) check("stall_len", 32'(stall_run), 32'(stall_q.pop_front()));
            stall_run = 0;
        end
    end

    function automatic req_t mk_req(input logic [31:0] ad, input logic [3:0] b,
                                    input logic w, input logic [31:0] wd);
        req_t r;
        r.addr = ad; r.be = b; r.we = w; r.wdata = wd;
        return r;
    endfunction

    // Called just after a rising edge; returns just after the edge leaving DONE
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] sz,
                             input logic [31:0] ad, input logic [31:0] w,
                             input int gdel, input int rvdel, input logic [31:0] rdat);
        int req_k = 0;
        int resp_k = 0;
        bit granted = 1'b0;
        bit fin = 1'b0;
        MemRead = rd; MemWrite = wr; MemSize = sz; ALUResult = ad; WriteData = w;
        for (int c = 0; c < 64 && !fin; c++) begin
            #1;
            if (bus.req) begin
                bus.gnt = (req_k == gdel);
                req_k++;
                if (bus.gnt) begin
                    granted = 1'b1;
                    if (rd && rvdel < 0) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = rdat;
                    end
                end
            end else if (granted && rd && StallM) begin
                bus.rvalid = (resp_k == rvdel);
                bus.rdata  = rdat;
                resp_k++;
            end
            if (!StallM) fin = 1'b1;
            @(posedge clk); #1;
            bus.gnt = 1'b0; bus.rvalid = 1'b0;
        end
        check("access_finished", 32'(fin), 32'd1);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 3'b010;
        ALUResult = '0; WriteData = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        #1;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // LW 0x100, gnt first REQ cycle, rvalid next cycle
        req_q.push_back(mk_req(32'h100, 4'b1111, 1'b0, 32'h0));
        rd_q.push_back(32'hDEADBEEF); stall_q.push_back(3);
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);

        // LB / LBU at byte 3
        req_q.push_back(mk_req(32'h200, 4'b1000, 1'b0, 32'h0));
        rd_q.push_back(32'hFFFFFF80); stall_q.push_back(3);
        do_access(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FF0000);
        req_q.push_back(mk_req(32'h200, 4'b1000, 1'b0, 32'h0));
        rd_q.push_back(32'h00000080); stall_q.push_back(3);
        do_access(1, 0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80FF0000);

        // SH upper half, grant withheld 3 cycles
        req_q.push_back(mk_req(32'h100, 4'b1100, 1'b1, 32'hABCDABCD));
        stall_q.push_back(5);
        do_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 3, 0, 32'h0);

        // Misaligned and illegal-size accesses
        mis_q.push_back(1);
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        mis_q.push_back(1);
        do_access(1, 0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
        mis_q.push_back(1);
        do_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        mis_q.push_back(1);
        do_access(0, 1, 3'b010, 32'h10E, 32'h55555555, 0, 0, 32'h0);

        // Grant never arrives: 16 REQ cycles then bus error
        err_q.push_back(1); stall_q.push_back(17);
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 99, 0, 32'h0);
        check("err_rdata_kept", ReadDataM, 32'h00000080);

        // SB lane 1
        req_q.push_back(mk_req(32'h000, 4'b0010, 1'b1, 32'hA5A5A5A5));
        stall_q.push_back(2);
        do_access(0, 1, 3'b000, 32'h001, 32'h000000A5, 0, 0, 32'h0);

        // LHU / LH with grant and rvalid in the same cycle
        req_q.push_back(mk_req(32'h200, 4'b1100, 1'b0, 32'h0));
        rd_q.push_back(32'h00008001); stall_q.push_back(3);
        do_access(1, 0, 3'b101, 32'h202, 32'h0, 1, -1, 32'h80011234);
        req_q.push_back(mk_req(32'h200, 4'b1100, 1'b0, 32'h0));
        rd_q.push_back(32'hFFFF8001); stall_q.push_back(2);
        do_access(1, 0, 3'b001, 32'h202, 32'h0, 0, -1, 32'h80011234);

        // Read and write both set: treated as a load, rvalid delayed
        req_q.push_back(mk_req(32'h500, 4'b1111, 1'b0, 32'h0));
        rd_q.push_back(32'h13579BDF); stall_q.push_back(5);
        do_access(1, 1, 3'b010, 32'h500, 32'h11111111, 0, 2, 32'h13579BDF);

        // SW and a positive LB at lane 1
        req_q.push_back(mk_req(32'h10C, 4'b1111, 1'b1, 32'hCAFEF00D));
        stall_q.push_back(2);
        do_access(0, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 0, 0, 32'h0);
        req_q.push_back(mk_req(32'h100, 4'b0010, 1'b0, 32'h0));
        rd_q.push_back(32'h0000007F); stall_q.push_back(3);
        do_access(1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h12347F56);

        // Reset during RESP aborts the load; a late rvalid is ignored
        req_q.push_back(mk_req(32'h300, 4'b1111, 1'b0, 32'h0));
        stall_q.push_back(3);
        MemRead = 1'b1; MemWrite = 1'b0; MemSize = 3'b010; ALUResult = 32'h300;
        @(posedge clk); #2 bus.gnt = 1'b1;
        @(posedge clk); #1 bus.gnt = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_stall", 32'(StallM), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(bus.req), 32'd0);
        check("arst_stall", 32'(StallM), 32'd0);
        check("arst_rdata", ReadDataM, 32'd0);
        MemRead = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.rvalid = 1'b1; bus.rdata = 32'hFFFFFFFF;
        rd_q.push_back(32'h0);
        @(posedge clk); #1 bus.rvalid = 1'b0;
        check("late_rvalid_no_req", 32'(bus.req), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("queues_drained",
              32'(req_q.size() + rd_q.size() + stall_q.size() + mis_q.size() + err_q.size()),
              32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
